// File: rtl/rfphoenix_pet_slave_if.sv
// Bus-side connection of the rfPhoenix precision event timer bank.
// The master drives the cycle; the slave answers with ack_o and dat_o.
interface rfphoenix_pet_slave_if;
    logic         cs_i;
    logic         cyc_i;
    logic         stb_i;
    logic         ack_o;
    logic         we_i;
    logic [15:0]  sel_i;
    logic [9:0]   adr_i;
    logic [127:0] dat_i;
    logic [127:0] dat_o;

    modport master (
        output cs_i, cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        input  ack_o, dat_o
    );

    modport slave (
        input  cs_i, cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        output ack_o, dat_o
    );
endinterface

// File: rtl/rfphoenix_pet_slave.sv
// Precision event timer bank on the rfPhoenix 128-bit bus (NTIMER timers, BITS-wide counters).
// Define RFPHOENIX_PET_GATE_EN to add the gate_i port and the CTRL.GE count gate.
module rfphoenix_pet_slave #(
    parameter int NTIMER = 4,
    parameter int BITS   = 48
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    rfphoenix_pet_slave_if.slave  bus,
`ifdef RFPHOENIX_PET_GATE_EN
    input  logic [NTIMER-1:0]     gate_i,
`endif
    output logic [NTIMER-1:0]     out_o,
    output logic                  irq_o
);
    logic         ack_reg;
    logic [127:0] dat_reg;
    logic         irq_reg;
    logic         req, start, wr_go;
    logic [2:0]   tsel;
    logic         blk_tmr, blk_glb, pair_hi;
    logic [63:0]  wlo, whi;
    logic [7:0]   sel_lo, sel_hi;
    logic [127:0] rd_data;
    logic         unused_adr;

    assign req     = bus.cs_i & bus.cyc_i & bus.stb_i;
    // A transfer is taken only once ack has returned low, so each write commits exactly once.
    assign start   = req & ~ack_reg;
    assign wr_go   = start & bus.we_i;
    assign tsel    = bus.adr_i[7:5];
    assign pair_hi = bus.adr_i[4];
    assign blk_tmr = (bus.adr_i[9:8] == 2'b00);
    assign blk_glb = (bus.adr_i[9:8] == 2'b01) && (bus.adr_i[7:4] == 4'h0);
    assign wlo     = bus.dat_i[63:0];
    assign whi     = bus.dat_i[127:64];
    assign sel_lo  = bus.sel_i[7:0];
    assign sel_hi  = bus.sel_i[15:8];
    assign unused_adr = ^bus.adr_i[3:0];

    function automatic logic [63:0] merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                          input logic [7:0] be);
        logic [63:0] res;
        for (int b = 0; b < 8; b++)
            res[b*8 +: 8] = be[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        return res;
    endfunction

    logic [BITS-1:0]   cnt_a [NTIMER];
    logic [BITS-1:0]   max_a [NTIMER];
    logic [BITS-1:0]   on_a  [NTIMER];
    logic [NTIMER-1:0] en_v, ar_v, ge_v, expire_v;

    for (genvar gi = 0; gi < NTIMER; gi++) begin : tmr_g
        logic [BITS-1:0] cnt_reg, cnt_next, max_reg, max_next, on_reg, on_next;
        logic            en_reg, en_next, ar_reg, ar_next, ge_reg, ge_next;
        logic            hit, run, expire;
        logic [63:0]     cnt_w, max_w, on_w;

        assign hit   = wr_go & blk_tmr & (tsel == 3'(gi));
        assign cnt_w = merge(64'(cnt_reg), wlo, sel_lo);
        assign max_w = merge(64'(max_reg), whi, sel_hi);
        assign on_w  = merge(64'(on_reg),  wlo, sel_lo);

        always_comb begin
            run = en_reg;
`ifdef RFPHOENIX_PET_GATE_EN
            if (ge_reg && !gate_i[gi])
                run = 1'b0;
`endif
            expire   = run && (cnt_reg == max_reg) && (max_reg != '0);
            cnt_next = cnt_reg;
            max_next = max_reg;
            on_next  = on_reg;
            en_next  = en_reg;
            ar_next  = ar_reg;
            ge_next  = ge_reg;
            if (expire) begin
                if (ar_reg) cnt_next = '0;
                else        en_next  = 1'b0;
            end else if (run) begin
                cnt_next = cnt_reg + 1'b1;
            end
            // Bus writes are applied last so they override the timer's own update.
            if (hit && !pair_hi) begin
                cnt_next = cnt_w[BITS-1:0];
                max_next = max_w[BITS-1:0];
            end
            if (hit && pair_hi) begin
                on_next = on_w[BITS-1:0];
                if (sel_hi[0]) begin
                    en_next = whi[0];
                    ar_next = whi[1];
`ifdef RFPHOENIX_PET_GATE_EN
                    ge_next = whi[3];
`endif
                    if (whi[2])
                        cnt_next = '0;
                end
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt_reg <= '0;
                max_reg <= '0;
                on_reg  <= '0;
                en_reg  <= 1'b0;
                ar_reg  <= 1'b0;
                ge_reg  <= 1'b0;
            end else begin
                cnt_reg <= cnt_next;
                max_reg <= max_next;
                on_reg  <= on_next;
                en_reg  <= en_next;
                ar_reg  <= ar_next;
                ge_reg  <= ge_next;
            end
        end

        assign cnt_a[gi]    = cnt_reg;
        assign max_a[gi]    = max_reg;
        assign on_a[gi]     = on_reg;
        assign en_v[gi]     = en_reg;
        assign ar_v[gi]     = ar_reg;
        assign ge_v[gi]     = ge_reg;
        assign expire_v[gi] = expire;
        assign out_o[gi]    = en_reg & (cnt_reg < on_reg);
    end

    logic [NTIMER-1:0] pend_reg, pend_next, ien_reg, ien_next;

    always_comb begin
        pend_next = pend_reg;
        ien_next  = ien_reg;
        if (wr_go && blk_glb && sel_lo[0])
            pend_next = pend_reg & ~wlo[NTIMER-1:0];
        if (wr_go && blk_glb && sel_hi[0])
            ien_next = whi[NTIMER-1:0];
        // Expiry is OR-ed after the clear so a colliding set wins.
        pend_next = pend_next | expire_v;
    end

    always_comb begin
        rd_data = '0;
        if (blk_tmr) begin
            for (int i = 0; i < NTIMER; i++) begin
                if (tsel == 3'(i)) begin
                    if (pair_hi)
                        rd_data = {60'd0, ge_v[i], 1'b0, ar_v[i], en_v[i], 64'(on_a[i])};
                    else
                        rd_data = {64'(max_a[i]), 64'(cnt_a[i])};
                end
            end
        end else if (blk_glb) begin
            rd_data = {64'(ien_reg), 64'(pend_reg)};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_reg  <= 1'b0;
            dat_reg  <= '0;
            irq_reg  <= 1'b0;
            pend_reg <= '0;
            ien_reg  <= '0;
        end else begin
            ack_reg  <= req;
            irq_reg  <= |(pend_reg & ien_reg);
            pend_reg <= pend_next;
            ien_reg  <= ien_next;
            if (start && !bus.we_i)
                dat_reg <= rd_data;
            else if (!req)
                dat_reg <= '0;
        end
    end

    assign bus.ack_o = ack_reg;
    assign bus.dat_o = dat_reg;
    assign irq_o     = irq_reg;
endmodule

// File: tb/tb_rfphoenix_pet_slave.sv
// Directed bench for rfphoenix_pet_slave: bus access, timer expiry, W1C collisions, byte lanes, gating.
module tb_rfphoenix_pet_slave;
    logic       clk;
    logic       rst;
    logic [3:0] out;
    logic       irq;
    int         n_total;
    int         n_bad;
    logic [127:0] rd;
`ifdef RFPHOENIX_PET_GATE_EN
    logic [3:0] gate;
`endif

    rfphoenix_pet_slave_if bus();

    rfphoenix_pet_slave #(.NTIMER(4), .BITS(48)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus),
`ifdef RFPHOENIX_PET_GATE_EN
        .gate_i(gate),
`endif
        .out_o (out),
        .irq_o (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        bus.cs_i  = 1'b0;
        bus.cyc_i = 1'b0;
        bus.stb_i = 1'b0;
        bus.we_i  = 1'b0;
    endtask

    task automatic bus_wr(input logic [9:0] a, input logic [15:0] s, input logic [127:0] d);
        @(negedge clk);
        bus.cs_i = 1'b1; bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1;
        bus.adr_i = a; bus.sel_i = s; bus.dat_i = d;
        #1 chk("wr_ack_pre", bus.ack_o, 1'b0);
        @(posedge clk); #1;
        chk("wr_ack", bus.ack_o, 1'b1);
        @(negedge clk);
        bus_idle();
        $display("wr adr=%h sel=%h dat=%h", a, s, d);
    endtask

    task automatic bus_rd(input logic [9:0] a, output logic [127:0] d);
        @(negedge clk);
        bus.cs_i = 1'b1; bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0;
        bus.adr_i = a; bus.sel_i = 16'hFFFF; bus.dat_i = '0;
        #1 chk("rd_ack_pre", bus.ack_o, 1'b0);
        @(posedge clk); #1;
        chk("rd_ack", bus.ack_o, 1'b1);
        d = bus.dat_o;
        @(negedge clk);
        bus_idle();
        $display("rd adr=%h dat=%h", a, d);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst = 1'b1;
        bus_idle();
        bus.adr_i = '0; bus.sel_i = '0; bus.dat_i = '0;
`ifdef RFPHOENIX_PET_GATE_EN
        gate = 4'h0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", bus.ack_o, 1'b0);
        chk("rst_dat", bus.dat_o, 128'h0);
        chk("rst_out", out, 4'h0);
        chk("rst_irq", irq, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_out", out, 4'h0);
        chk("post_rst_irq", irq, 1'b0);
        bus_rd(10'h000, rd);
        chk("rst_rd_000", rd, 128'h0);

        // Timer 0: MAX=9, ON=4, auto-reload, interrupt enabled
        bus_wr(10'h100, 16'hFF00, {64'd1, 64'd0});
        bus_wr(10'h000, 16'hFFFF, {64'd9, 64'd0});
        bus_wr(10'h010, 16'hFFFF, {64'd3, 64'd4});
        begin
            int highs;
            highs = 0;
            for (int k = 1; k <= 20; k++) begin
                @(posedge clk); #1;
                chk($sformatf("t0_out_k%0d", k), out[0], ((k % 10) < 4) ? 1'b1 : 1'b0);
                chk($sformatf("t0_irq_k%0d", k), irq, (k >= 11) ? 1'b1 : 1'b0);
                if (out[0]) highs++;
            end
            chk("t0_out_duty", 128'(highs), 128'd8);
        end

        // PEND clear on the exact expiry edge (k=30) must leave PEND set
        repeat (9) @(posedge clk);
        bus_wr(10'h100, 16'h00FF, {64'd0, 64'd1});
        bus_rd(10'h100, rd);
        chk("pend_collide", rd, {64'd1, 64'd1});
        chk("irq_collide", irq, 1'b1);
        bus_wr(10'h100, 16'h00FF, {64'd0, 64'd1});
        @(posedge clk); #1;
        chk("irq_cleared", irq, 1'b0);
        bus_wr(10'h010, 16'h0100, 128'h0);
        repeat (15) @(posedge clk);
        #1;
        chk("t0_stopped_out", out[0], 1'b0);
        chk("t0_stopped_irq", irq, 1'b0);
        bus_rd(10'h100, rd);
        chk("pend_after_stop", rd, {64'd1, 64'd0});

        // Timer 1: one-shot to MAX=5
        bus_wr(10'h020, 16'hFFFF, {64'd5, 64'd0});
        bus_wr(10'h030, 16'h0100, {64'd1, 64'd0});
        repeat (10) @(posedge clk);
        bus_rd(10'h020, rd);
        chk("t1_hold", rd, {64'd5, 64'd5});
        repeat (5) @(posedge clk);
        bus_rd(10'h020, rd);
        chk("t1_hold_later", rd, {64'd5, 64'd5});
        bus_rd(10'h030, rd);
        chk("t1_en_clear", rd, 128'h0);
        bus_rd(10'h100, rd);
        chk("t1_pend", rd, {64'd1, 64'd2});
        chk("t1_irq_masked", irq, 1'b0);
        chk("t1_out", out[1], 1'b0);
        bus_wr(10'h100, 16'h00FF, {64'd0, 64'd2});
        bus_wr(10'h030, 16'h0100, {64'd4, 64'd0});
        bus_rd(10'h020, rd);
        chk("t1_ld", rd, {64'd5, 64'd0});
        bus_rd(10'h030, rd);
        chk("t1_ld_reads0", rd, 128'h0);
        bus_rd(10'h100, rd);
        chk("t1_pend_clr", rd, {64'd1, 64'd0});

        // Byte-lane write touches only MAX0[7:0]
        bus_wr(10'h000, 16'h00FF, {64'd0, 64'h1234});
        bus_wr(10'h000, 16'h0100, {64'h5555_5555_5555_55AA, 64'h5555_5555_5555_5555});
        bus_rd(10'h000, rd);
        chk("byte_lane", rd, {64'hAA, 64'h1234});
        @(posedge clk); #1;
        chk("ack_drop", bus.ack_o, 1'b0);
        chk("dat_zero", bus.dat_o, 128'h0);

        // Unmapped space: acknowledged, reads zero, writes ignored
        bus_wr(10'h0A0, 16'hFFFF, {64'hFFFF, 64'hFFFF});
        bus_rd(10'h0A0, rd);
        chk("unmapped_t5", rd, 128'h0);
        bus_rd(10'h110, rd);
        chk("unmapped_110", rd, 128'h0);
        bus_rd(10'h200, rd);
        chk("unmapped_200", rd, 128'h0);

        // Timer 2 gate enable
        bus_wr(10'h040, 16'hFFFF, 128'h0);
        bus_wr(10'h050, 16'h0100, {64'd9, 64'd0});
`ifdef RFPHOENIX_PET_GATE_EN
        for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            gate = 4'h4;
            @(negedge clk);
            gate = 4'h0;
            @(negedge clk);
        end
        bus_rd(10'h040, rd);
        chk("t2_gated_count", rd, {64'd0, 64'd3});
        bus_rd(10'h050, rd);
        chk("t2_ctrl_ge", rd, {64'd9, 64'd0});
`else
        bus_rd(10'h050, rd);
        chk("t2_ctrl_no_ge", rd, {64'd1, 64'd0});
`endif
        bus_wr(10'h050, 16'h0100, 128'h0);

        // Asynchronous reset during an acknowledged read
        @(negedge clk);
        bus.cs_i = 1'b1; bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0;
        bus.adr_i = 10'h000; bus.sel_i = 16'hFFFF;
        @(posedge clk); #1;
        chk("pre_rst_ack", bus.ack_o, 1'b1);
        chk("pre_rst_dat", bus.dat_o, {64'hAA, 64'h1234});
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ack", bus.ack_o, 1'b0);
        chk("async_rst_dat", bus.dat_o, 128'h0);
        bus_idle();
        @(negedge clk);
        rst = 1'b0;
        bus_rd(10'h000, rd);
        chk("after_rst_regs", rd, 128'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/rfphoenix_pet_slave.md
# rfphoenix_pet_slave

Precision event timer bank that answers on the rfPhoenix 128-bit system bus as a bus responder. The CPU-side MPU initiates the cycles; this block decodes them, acknowledges them and returns read data. Its per-timer outputs feed the PIC: timer 0 is the time-slice interrupt, and timers 1..NTIMER-1 are OR-ed into the event interrupt. Read data is zero whenever the block is not acknowledging, so it can sit on the MPU's OR-combined read-data path.

## Interface
- NTIMER, 4: number of timers, 1..8.
- BITS, 48: counter width, 16..64. Registers read zero-extended to 64 bits.
- rst_i  in  1  asynchronous active-high reset
- clk_i  in  1  system clock; also the count clock
- cs_i  in  1  chip select, decoded upstream from adr[31:12]==20'hFF960
- cyc_i, stb_i  in  1 each  bus cycle and strobe
- ack_o  out  1  transfer acknowledge
- we_i  in  1  write enable
- sel_i  in  16  byte lane selects; [7:0] address the low dword, [15:8] the high dword
- adr_i  in  10  byte address within the block; bits [3:0] are ignored
- dat_i  in  128  write data
- dat_o  out  128  read data; zero when ack_o=0
- gate_i  in  NTIMER  per-timer count gate; present only with RFPHOENIX_PET_GATE_EN
- out_o  out  NTIMER  per-timer PWM/compare output
- irq_o  out  1  OR of (pending & irq_enable)

## Operation
- Timer t has a 32-byte block at adr_i[7:5]=t:
  - +0x00 COUNT (read/write)
  - +0x08 MAX (read/write)
  - +0x10 ON (read/write)
  - +0x18 CTRL, bit0 EN, bit1 AR (auto-reload), bit2 LD (write-only strobe; reads 0), bit3 GE (gate enable)
- Global registers at adr_i[9:8]=2'b01:
  - 0x100 PEND (bit t per timer; write 1 to clear)
  - 0x108 IEN (read/write)
- A 128-bit beat covers two registers: dat[63:0] is the register at adr with bit3=0, dat[127:64] the register at adr with bit3=1.
- Writes are byte-lane masked by sel_i.
- Reads ignore sel_i and return both halves.
- Unmapped addresses read zero, ignore writes, and are still acknowledged.
- Count rule, applied each clock while EN=1 (and gate_i[t]=1 if GE=1):
  - If COUNT==MAX and MAX!=0: set PEND[t]. If AR=1, COUNT<=0; otherwise EN<=0 and COUNT holds.
  - Otherwise: COUNT<=COUNT+1, wrapping modulo 2^BITS.
- MAX=0 never expires; the counter free-runs and wraps.
- Writing LD=1 forces COUNT<=0 on that cycle and overrides counting.
- out_o[t] = EN & (COUNT < ON). ON=0 gives a constant 0; ON>MAX gives a constant 1 while enabled.
- Same-cycle collisions:
  - A bus write to COUNT or CTRL beats the count/expiry update of the same field.
  - An expiry set and a W1C clear of the same PEND bit resolve to set.

## Timing
- req = cs_i & cyc_i & stb_i.
- ack_o is registered: ack_o <= req. It appears one clock after req and stays high while req holds. It drops one clock after req falls.
- The write commits once, on the edge where req=1 and ack_o=0. Read data is registered on the same edge.
- A new transfer is recognised only after ack_o has returned low.
- Reset values: ack_o=0, dat_o=0, out_o=0, irq_o=0, and all COUNT/MAX/ON/CTRL/PEND/IEN=0.
- Reset asserted mid-transfer clears ack_o and dat_o immediately. No write is committed after reset.
- Output latency:
  - irq_o is registered; it rises one clock after PEND is set.
  - out_o is combinational from the registers.

## Configuration
- RFPHOENIX_PET_GATE_EN defined:
  - gate_i exists and CTRL.GE is implemented.
  - With GE=1, counting advances only on cycles where gate_i[t]=1. Expiry is evaluated only on those cycles.
- Undefined:
  - No gate_i port.
  - GE reads 0 and ignores writes.
  - Timers count every enabled clock.

## Test plan
- Reset held, then released -> every output is 0; a read of 0x000 (sel=16'hFFFF) returns 128'h0 with ack_o high exactly one clock after stb_i.
- Write MAX0=9, ON0=4, IEN=1, CTRL0=3 (EN|AR) -> out_o[0] is high for 4 of every 10 clocks; PEND[0] sets every 10 clocks; irq_o follows one clock later.
- Write CTRL1=1 with AR=0 and MAX1=5 -> COUNT1 reaches 5, PEND[1]=1, EN clears, and COUNT1 then reads 5 indefinitely.
- Write PEND=1 on the same cycle timer 0 expires -> PEND[0] stays 1. A following write of PEND=1 with no expiry clears it, and irq_o drops.
- Byte-lane write of sel=16'h0100 with dat_i[71:64]=8'hAA to 0x000 -> only MAX0[7:0]=8'hAA changes; COUNT0 is unchanged; dat_o returns 0 after ack_o drops.
- With RFPHOENIX_PET_GATE_EN: GE=1, EN=1, gate_i[2] pulsed 3 times -> COUNT2 reads 3. Without the macro, the same test reads CTRL.GE=0.
